uart_rx: RTL and testbench

UART_RX -- requirements
Module: UART_rx

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_rx_datapath.sv | 173 +++++++++++++++++
 rtl/uart_rx_fsm.sv | 146 ++++++++++++++
 rtl/uart_rx.sv | 89 ++++++++
 tb/tb_uart_rx.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and defaults for the UART receiver slice.
//   rx_state_e     - receiver control states
//   DEF_DATA_BITS  - default data bits per frame
//   DEF_OVERSAMPLE - default sample ticks per bit
//   eff_div()      - baud divisor with 0 mapped to 1
package uart_pkg;

   localparam int unsigned DEF_DATA_BITS  = 8;
   localparam int unsigned DEF_OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_START,
      ST_DATA,
      ST_PARITY,
      ST_STOP,
      ST_BREAK
   } rx_state_e;

   function automatic logic [15:0] eff_div(input logic [15:0] div);
      return (div == 16'd0) ? 16'd1 : div;
   endfunction

endpackage

// File: rtl/uart_rx_datapath.sv
// uart_rx_datapath: synchronizer, tick divider, shift register, output buffer.
//   in : clk, rst_n, rx, baud_div, parity_en, parity_odd, stop2, rx_ready,
//        err_clr, and control strobes from uart_rx_fsm
//   out: rx_sync, rx_fall, tick, cfg_parity_en, cfg_stop2, data_zero, ferr_now
//        (to control), rx_data, rx_valid, parity_err, frame_err, overrun
module uart_rx_datapath
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS = DEF_DATA_BITS
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   input  logic [15:0]          baud_div,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 stop2,
   input  logic                 rx_ready,
   input  logic                 err_clr,
   input  logic                 busy,
   input  logic                 start_go,
   input  logic                 shift_en,
   input  logic                 par_smp,
   input  logic                 stop_smp,
   input  logic                 frame_end,
   output logic                 rx_sync,
   output logic                 rx_fall,
   output logic                 tick,
   output logic                 cfg_parity_en,
   output logic                 cfg_stop2,
   output logic                 data_zero,
   output logic                 ferr_now,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun
);

   logic                 sync1_q, sync1_d;
   logic                 sync2_q, sync2_d;
   logic                 prev_q, prev_d;
   logic [15:0]          cfg_div_q, cfg_div_d;
   logic                 cfg_pen_q, cfg_pen_d;
   logic                 cfg_podd_q, cfg_podd_d;
   logic                 cfg_s2_q, cfg_s2_d;
   logic [15:0]          div_cnt_q, div_cnt_d;
   logic [DATA_BITS-1:0] shift_q, shift_d;
   logic                 par_bit_q, par_bit_d;
   logic                 ferr_q, ferr_d;
   logic                 load_pend_q, load_pend_d;
   logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
   logic                 rx_valid_q, rx_valid_d;
   logic                 perr_q, perr_d;
   logic                 ferr_out_q, ferr_out_d;
   logic                 ovr_q, ovr_d;
   logic [15:0]          div_last;
   logic                 load_ok;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q     <= 1'b1;
         sync2_q     <= 1'b1;
         prev_q      <= 1'b1;
         cfg_div_q   <= '0;
         cfg_pen_q   <= 1'b0;
         cfg_podd_q  <= 1'b0;
         cfg_s2_q    <= 1'b0;
         div_cnt_q   <= '0;
         shift_q     <= '0;
         par_bit_q   <= 1'b0;
         ferr_q      <= 1'b0;
         load_pend_q <= 1'b0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         perr_q      <= 1'b0;
         ferr_out_q  <= 1'b0;
         ovr_q       <= 1'b0;
      end else begin
         sync1_q     <= sync1_d;
         sync2_q     <= sync2_d;
         prev_q      <= prev_d;
         cfg_div_q   <= cfg_div_d;
         cfg_pen_q   <= cfg_pen_d;
         cfg_podd_q  <= cfg_podd_d;
         cfg_s2_q    <= cfg_s2_d;
         div_cnt_q   <= div_cnt_d;
         shift_q     <= shift_d;
         par_bit_q   <= par_bit_d;
         ferr_q      <= ferr_d;
         load_pend_q <= load_pend_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         perr_q      <= perr_d;
         ferr_out_q  <= ferr_out_d;
         ovr_q       <= ovr_d;
      end
   end

   assign div_last = eff_div(cfg_div_q) - 16'd1;
   assign tick     = busy & (div_cnt_q == div_last);
   assign load_ok  = load_pend_q & (~rx_valid_q | rx_ready);

   always_comb begin
      sync1_d     = rx;
      sync2_d     = sync1_q;
      prev_d      = sync2_q;
      cfg_div_d   = cfg_div_q;
      cfg_pen_d   = cfg_pen_q;
      cfg_podd_d  = cfg_podd_q;
      cfg_s2_d    = cfg_s2_q;
      div_cnt_d   = '0;
      shift_d     = shift_q;
      par_bit_d   = par_bit_q;
      ferr_d      = ferr_q;
      load_pend_d = frame_end;
      rx_data_d   = rx_data_q;
      rx_valid_d  = rx_valid_q;
      perr_d      = perr_q;
      ferr_out_d  = ferr_out_q;
      ovr_d       = ovr_q;

      // Frame configuration is frozen for the whole frame at START entry.
      if (start_go) begin
         cfg_div_d  = baud_div;
         cfg_pen_d  = parity_en;
         cfg_podd_d = parity_odd;
         cfg_s2_d   = stop2;
         ferr_d     = 1'b0;
      end else if (busy) begin
         div_cnt_d = tick ? '0 : div_cnt_q + 16'd1;
      end

      if (shift_en) begin
         shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
      end
      if (par_smp) begin
         par_bit_d = sync2_q;
      end
      if (stop_smp) begin
         ferr_d = ferr_now;
      end

      // A new word loading overrides the handshake clearing rx_valid.
      if (load_ok) begin
         rx_data_d  = shift_q;
         rx_valid_d = 1'b1;
         perr_d     = cfg_pen_q & ((^shift_q ^ par_bit_q) != cfg_podd_q);
         ferr_out_d = ferr_q;
      end else if (rx_valid_q && rx_ready) begin
         rx_valid_d = 1'b0;
      end

      if (load_pend_q && !load_ok) begin
         ovr_d = 1'b1;
      end else if (err_clr) begin
         ovr_d = 1'b0;
      end
   end

   assign rx_sync       = sync2_q;
   assign rx_fall       = prev_q & ~sync2_q;
   assign cfg_parity_en = cfg_pen_q;
   assign cfg_stop2     = cfg_s2_q;
   assign data_zero     = (shift_q == '0);
   assign ferr_now      = ferr_q | (stop_smp & ~sync2_q);
   assign rx_data       = rx_data_q;
   assign rx_valid      = rx_valid_q;
   assign parity_err    = perr_q;
   assign frame_err     = ferr_out_q;
   assign overrun       = ovr_q;

endmodule

// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: frame sequencing for the UART receiver.
//   in : clk, rst_n, rx_sync (synchronized line), rx_fall (1->0 edge),
//        tick (sample tick), cfg_parity_en/cfg_stop2 (per-frame config),
//        data_zero (shift register all 0), ferr_now (frame error incl. this sample)
//   out: busy, start_go (START entry), shift_en (data sample), par_smp (parity
//        sample), stop_smp (stop sample), frame_end (final stop sample)
module uart_rx_fsm
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
   parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic clk,
   input  logic rst_n,
   input  logic rx_sync,
   input  logic rx_fall,
   input  logic tick,
   input  logic cfg_parity_en,
   input  logic cfg_stop2,
   input  logic data_zero,
   input  logic ferr_now,
   output logic busy,
   output logic start_go,
   output logic shift_en,
   output logic par_smp,
   output logic stop_smp,
   output logic frame_end
);

   localparam int unsigned TW = $clog2(OVERSAMPLE);
   localparam int unsigned BW = $clog2(DATA_BITS);
   localparam logic [TW-1:0] HALF_TICK = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

   rx_state_e     state_q, state_d;
   logic [TW-1:0] tick_cnt_q, tick_cnt_d;
   logic [BW-1:0] bit_cnt_q, bit_cnt_d;
   logic          stop_cnt_q, stop_cnt_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         tick_cnt_q <= '0;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         tick_cnt_q <= tick_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      tick_cnt_d = tick_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      start_go   = 1'b0;
      shift_en   = 1'b0;
      par_smp    = 1'b0;
      stop_smp   = 1'b0;
      frame_end  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (rx_fall) begin
               state_d    = ST_START;
               start_go   = 1'b1;
               tick_cnt_d = '0;
               bit_cnt_d  = '0;
               stop_cnt_d = 1'b0;
            end
         end

         // Re-check the start bit near its middle; a high line here is a glitch.
         ST_START: begin
            if (tick) begin
               if (tick_cnt_q == HALF_TICK) begin
                  tick_cnt_d = '0;
                  state_d    = rx_sync ? ST_IDLE : ST_DATA;
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
         end

         ST_DATA: begin
            if (tick) begin
               if (tick_cnt_q == LAST_TICK) begin
                  tick_cnt_d = '0;
                  shift_en   = 1'b1;
                  bit_cnt_d  = bit_cnt_q + BW'(1);
                  if (bit_cnt_q == LAST_BIT) begin
                     state_d = cfg_parity_en ? ST_PARITY : ST_STOP;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
         end

         ST_PARITY: begin
            if (tick) begin
               if (tick_cnt_q == LAST_TICK) begin
                  tick_cnt_d = '0;
                  par_smp    = 1'b1;
                  state_d    = ST_STOP;
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
         end

         // ferr_now already folds in the stop sample taken this cycle.
         ST_STOP: begin
            if (tick) begin
               if (tick_cnt_q == LAST_TICK) begin
                  tick_cnt_d = '0;
                  stop_smp   = 1'b1;
                  if (cfg_stop2 && !stop_cnt_q) begin
                     stop_cnt_d = 1'b1;
                  end else begin
                     frame_end = 1'b1;
                     state_d   = (ferr_now && data_zero) ? ST_BREAK : ST_IDLE;
                  end
               end else begin
                  tick_cnt_d = tick_cnt_q + TW'(1);
               end
            end
         end

         ST_BREAK: begin
            if (rx_sync) begin
               state_d = ST_IDLE;
            end
         end

         default: state_d = ST_IDLE;
      endcase
   end

   assign busy = (state_q != ST_IDLE);

endmodule

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with single-word output buffer.
//   clk, rst_n                  - clock, asynchronous active-low reset
//   rx                          - serial line (idle high, asynchronous)
//   baud_div                    - clocks per sample tick (0 acts as 1)
//   parity_en/parity_odd/stop2  - frame format, latched at frame start
//   rx_data/rx_valid/rx_ready   - received word handshake
//   parity_err/frame_err        - status of the held word
//   overrun/err_clr             - sticky lost-frame flag and its clear
//   busy                        - a frame (or break) is in progress
module uart_rx
   import uart_pkg::*;
#(
   parameter int unsigned DATA_BITS  = DEF_DATA_BITS,
   parameter int unsigned OVERSAMPLE = DEF_OVERSAMPLE
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 rx,
   input  logic [15:0]          baud_div,
   input  logic                 parity_en,
   input  logic                 parity_odd,
   input  logic                 stop2,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   input  logic                 err_clr,
   output logic                 busy
);

   logic rx_sync, rx_fall, tick, cfg_parity_en, cfg_stop2, data_zero, ferr_now;
   logic start_go, shift_en, par_smp, stop_smp, frame_end;

   uart_rx_fsm #(
      .DATA_BITS (DATA_BITS),
      .OVERSAMPLE(OVERSAMPLE)
   ) u_fsm (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_sync      (rx_sync),
      .rx_fall      (rx_fall),
      .tick         (tick),
      .cfg_parity_en(cfg_parity_en),
      .cfg_stop2    (cfg_stop2),
      .data_zero    (data_zero),
      .ferr_now     (ferr_now),
      .busy         (busy),
      .start_go     (start_go),
      .shift_en     (shift_en),
      .par_smp      (par_smp),
      .stop_smp     (stop_smp),
      .frame_end    (frame_end)
   );

   uart_rx_datapath #(
      .DATA_BITS(DATA_BITS)
   ) u_dp (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx           (rx),
      .baud_div     (baud_div),
      .parity_en    (parity_en),
      .parity_odd   (parity_odd),
      .stop2        (stop2),
      .rx_ready     (rx_ready),
      .err_clr      (err_clr),
      .busy         (busy),
      .start_go     (start_go),
      .shift_en     (shift_en),
      .par_smp      (par_smp),
      .stop_smp     (stop_smp),
      .frame_end    (frame_end),
      .rx_sync      (rx_sync),
      .rx_fall      (rx_fall),
      .tick         (tick),
      .cfg_parity_en(cfg_parity_en),
      .cfg_stop2    (cfg_stop2),
      .data_zero    (data_zero),
      .ferr_now     (ferr_now),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .parity_err   (parity_err),
      .frame_err    (frame_err),
      .overrun      (overrun)
   );

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx. Frames are serialised bit by bit;
// the expected word is queued when a frame is issued and a monitor pops and
// compares it whenever the DUT completes an rx_valid/rx_ready handshake.
module tb_uart_rx;

   localparam int unsigned DB = 8;
   localparam int unsigned OS = 16;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rx;
   logic [15:0] baud_div;
   logic        parity_en, parity_odd, stop2;
   logic [DB-1:0] rx_data;
   logic        rx_valid, rx_ready;
   logic        parity_err, frame_err, overrun;
   logic        err_clr;
   logic        busy;

   uart_rx #(
      .DATA_BITS (DB),
      .OVERSAMPLE(OS)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rx        (rx),
      .baud_div  (baud_div),
      .parity_en (parity_en),
      .parity_odd(parity_odd),
      .stop2     (stop2),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_ready  (rx_ready),
      .parity_err(parity_err),
      .frame_err (frame_err),
      .overrun   (overrun),
      .err_clr   (err_clr),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [DB-1:0] data;
      logic          perr;
      logic          ferr;
   } exp_t;

   exp_t        sb[$];
   exp_t        mon_e;
   int          errors = 0;
   int          checks = 0;
   int unsigned cyc = 0;
   int unsigned rise_cyc = 0;
   int unsigned frame_t0 = 0;
   logic        valid_prev = 1'b0;
   logic        exp_ovr = 1'b0;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: record rx_valid rise time, compare each accepted word.
   always @(negedge clk) begin
      if (!rst_n) begin
         valid_prev = 1'b0;
      end else begin
         if (rx_valid && !valid_prev) rise_cyc = cyc;
         if (rx_valid && rx_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_word: got data %0h, expected no word", rx_data);
            end else begin
               mon_e = sb.pop_front();
               check("rx_data", {24'd0, rx_data}, {24'd0, mon_e.data});
               check("parity_err", {31'd0, parity_err}, {31'd0, mon_e.perr});
               check("frame_err", {31'd0, frame_err}, {31'd0, mon_e.ferr});
            end
         end
         valid_prev = rx_valid;
      end
   end

   function automatic int unsigned bit_clks();
      return OS * ((baud_div == 16'd0) ? 1 : int'(baud_div));
   endfunction

   // Reference: parity error when the count of ones over data+parity bit
   // has the wrong oddness; a held word makes a new frame an overrun.
   task automatic expect_word(input logic [DB-1:0] d, input logic pbit, input logic fe);
      int   ones;
      exp_t e;
      ones = 0;
      for (int i = 0; i < int'(DB); i++) ones += int'(d[i]);
      e.data = d;
      e.perr = parity_en ? ((((ones + int'(pbit)) % 2) == 1) != parity_odd) : 1'b0;
      e.ferr = fe;
      if (!rx_ready && sb.size() > 0) exp_ovr = 1'b1;
      else sb.push_back(e);
   endtask

   task automatic drive_bit(input logic b);
      rx = b;
      repeat (bit_clks()) @(negedge clk);
   endtask

   task automatic send_frame(input logic [DB-1:0] d, input logic pbit,
                             input logic bad1, input logic bad2);
      expect_word(d, pbit, bad1 | (stop2 & bad2));
      frame_t0 = cyc;
      drive_bit(1'b0);
      for (int i = 0; i < int'(DB); i++) drive_bit(d[i]);
      if (parity_en) drive_bit(pbit);
      drive_bit(~bad1);
      if (stop2) drive_bit(~bad2);
      rx = 1'b1;
      repeat (2 * bit_clks()) @(negedge clk);
   endtask

   task automatic wait_idle(input string name);
      for (int i = 0; i < int'(4 * bit_clks()) && busy; i++) @(negedge clk);
      check(name, {31'd0, busy}, 32'd0);
   endtask

   int unsigned lat;

   initial begin
      rst_n = 1'b0; rx = 1'b1; baud_div = 16'd1;
      parity_en = 1'b0; parity_odd = 1'b0; stop2 = 1'b0;
      rx_ready = 1'b1; err_clr = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("reset_rx_data", {24'd0, rx_data}, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_overrun", {31'd0, overrun}, 32'd0);
      check("reset_errs", {30'd0, parity_err, frame_err}, 32'd0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // 8N1, baud_div=1: word appears after the stop-bit middle, within the stop bit.
      send_frame(8'hA5, 1'b0, 1'b0, 1'b0);
      lat = rise_cyc - frame_t0;
      check("valid_latency_in_stop_bit", {31'd0, (lat >= 153 && lat <= 160)}, 32'd1);

      // Even parity with wrong then right parity bit.
      parity_en = 1'b1; parity_odd = 1'b0;
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      send_frame(8'h3C, 1'b0, 1'b0, 1'b0);
      parity_en = 1'b0;

      // 4-tick glitch must be rejected.
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      wait_idle("glitch_busy_idle");
      send_frame(8'h5A, 1'b0, 1'b0, 1'b0);

      // Break: 20 bit times low.
      expect_word(8'h00, 1'b0, 1'b1);
      rx = 1'b0;
      repeat (15 * bit_clks()) @(negedge clk);
      check("break_holds_busy", {31'd0, busy}, 32'd1);
      repeat (5 * bit_clks()) @(negedge clk);
      check("break_still_busy_while_low", {31'd0, busy}, 32'd1);
      rx = 1'b1;
      wait_idle("break_exit_idle");
      repeat (bit_clks()) @(negedge clk);

      // Overrun with consumer stalled.
      rx_ready = 1'b0;
      repeat (2) @(negedge clk);
      send_frame(8'h11, 1'b0, 1'b0, 1'b0);
      send_frame(8'h22, 1'b0, 1'b0, 1'b0);
      check("ovr_set", {31'd0, overrun}, {31'd0, exp_ovr});
      check("ovr_held_data", {24'd0, rx_data}, 32'h11);
      check("ovr_held_valid", {31'd0, rx_valid}, 32'd1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      exp_ovr = 1'b0;
      check("ovr_cleared", {31'd0, overrun}, {31'd0, exp_ovr});
      send_frame(8'h33, 1'b0, 1'b0, 1'b0);
      check("ovr_set_again", {31'd0, overrun}, {31'd0, exp_ovr});

      // Reset in the middle of the data bits of 0xFF.
      drive_bit(1'b0);
      drive_bit(1'b1);
      drive_bit(1'b1);
      drive_bit(1'b1);
      repeat (5) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("midrst_rx_valid", {31'd0, rx_valid}, 32'd0);
      check("midrst_rx_data", {24'd0, rx_data}, 32'd0);
      check("midrst_overrun", {31'd0, overrun}, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_errs", {30'd0, parity_err, frame_err}, 32'd0);
      sb.delete();
      exp_ovr = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      rx_ready = 1'b1;
      repeat (7 * bit_clks()) @(negedge clk);
      check("midrst_no_frame_busy", {31'd0, busy}, 32'd0);
      check("midrst_no_frame_valid", {31'd0, rx_valid}, 32'd0);

      // Randomized frames, formats, rates, consumer stalls and errors.
      for (int n = 0; n < 24; n++) begin
         logic [DB-1:0] d;
         logic pb, b1, b2;
         rx_ready   = ($urandom_range(0, 3) != 0);
         baud_div   = 16'($urandom_range(0, 3));
         parity_en  = 1'($urandom_range(0, 1));
         parity_odd = 1'($urandom_range(0, 1));
         stop2      = 1'($urandom_range(0, 1));
         d  = ($urandom_range(0, 7) == 0) ? '0 : DB'($urandom);
         pb = 1'($urandom_range(0, 1));
         b1 = ($urandom_range(0, 7) == 0);
         b2 = ($urandom_range(0, 7) == 0);
         repeat (3) @(negedge clk);
         send_frame(d, pb, b1, b2);
         check("rand_overrun", {31'd0, overrun}, {31'd0, exp_ovr});
      end

      rx_ready = 1'b1;
      for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
      check("scoreboard_drained", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
